// File: rtl/cpu_defs.sv
// Shared CPU definitions for the writeback path.
// Provides register-file geometry, the zero-register index, the arbitration
// mode encodings and the grant-state enum used by the writeback arbiter.
package cpu_defs;

  localparam int REG_ADDR_W  = 5;
  localparam int REG_DATA_W  = 32;
  localparam int REG_COUNT   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Arbitration modes
  localparam int PRI_RR      = 0;  // alternate between A and B under contention
  localparam int PRI_FIXED_B = 1;  // B always wins under contention

  // Which requester won the most recent arbitration
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way writeback arbiter.
// Ports:
//   Clk, Reset      : clock, synchronous active-high reset
//   AValid, BValid  : request lines
//   GrantA, GrantB  : combinational grants, at most one high, never without
//                     the matching request; both low while Reset is high
//   LastGrantB      : state, 1 = B won the last arbitration (reset value 1 so
//                     that A is favoured first)
// Handshake: a requester holds Valid (and its payload) until it sees its
// Grant high in a cycle; the transfer happens at the rising edge ending that
// cycle.
module rr_arbiter2
  import cpu_defs::*;
#(
  parameter int PRIORITY_MODE = PRI_RR
) (
  input  logic Clk,
  input  logic Reset,
  input  logic AValid,
  input  logic BValid,
  output logic GrantA,
  output logic GrantB,
  output logic LastGrantB
);

  grant_e lastGrant;

  always_comb begin
    GrantA = 1'b0;
    GrantB = 1'b0;
    if (!Reset) begin
      if (AValid && BValid) begin
        if (PRIORITY_MODE == PRI_FIXED_B) begin
          GrantB = 1'b1;
        end else if (lastGrant == GRANT_B) begin
          GrantA = 1'b1;
        end else begin
          GrantB = 1'b1;
        end
      end else begin
        GrantA = AValid;
        GrantB = BValid;
      end
    end
  end

  // Grant state only moves when a grant actually happens; idle cycles hold it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lastGrant <= GRANT_B;
    end else if (GrantB) begin
      lastGrant <= GRANT_B;
    end else if (GrantA) begin
      lastGrant <= GRANT_A;
    end
  end

  assign LastGrantB = (lastGrant == GRANT_B);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file's single write port.
// Requester A (ALU result) and requester B (load data) compete for the port;
// the winner's address/data are registered and presented to the register
// file one cycle later.
// Ports:
//   Clk, Reset                    : clock, synchronous active-high reset
//   AValid/AReady/AAddr/AData     : requester A handshake and payload
//   BValid/BReady/BAddr/BData     : requester B handshake and payload
//   RegWrite/WriteRegister/WriteData : registered regfile write port
//   ReadRegister1/2               : regfile read addresses for hazard check
//   Hazard1/2                     : read address matches the in-flight write
//   PendingMask                   : one-hot of the register being written
//   LastGrantB                    : arbitration state, 1 = B won last
// Handshake: Valid with payload is held stable until Ready is seen high;
// Ready high means the write is accepted at the edge ending that cycle.
module regfile_wb_arbiter
  import cpu_defs::*;
#(
  parameter int PRIORITY_MODE = PRI_RR,
  parameter int DROP_ZERO     = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AValid,
  output logic        AReady,
  input  logic [4:0]  AAddr,
  input  logic [31:0] AData,
  input  logic        BValid,
  output logic        BReady,
  input  logic [4:0]  BAddr,
  input  logic [31:0] BData,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Hazard1,
  output logic        Hazard2,
  output logic [31:0] PendingMask,
  output logic        LastGrantB
);

  logic                  grantA;
  logic                  grantB;
  logic [REG_ADDR_W-1:0] selAddr;
  logic [REG_DATA_W-1:0] selData;
  logic                  regWriteQ;
  logic [REG_ADDR_W-1:0] writeRegQ;
  logic [REG_DATA_W-1:0] writeDataQ;

  rr_arbiter2 #(
    .PRIORITY_MODE(PRIORITY_MODE)
  ) uArb (
    .Clk        (Clk),
    .Reset      (Reset),
    .AValid     (AValid),
    .BValid     (BValid),
    .GrantA     (grantA),
    .GrantB     (grantB),
    .LastGrantB (LastGrantB)
  );

  assign AReady  = grantA;
  assign BReady  = grantB;
  assign selAddr = grantB ? BAddr : AAddr;
  assign selData = grantB ? BData : AData;

  // Address/data hold when idle; only the enable drops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else if (grantA || grantB) begin
      writeRegQ  <= selAddr;
      writeDataQ <= selData;
      regWriteQ  <= !((DROP_ZERO != 0) && (selAddr == ZERO_REG));
    end else begin
      regWriteQ  <= 1'b0;
    end
  end

  // Reset asserted during the write cycle must still cancel that write, so
  // the registered enable is squashed while Reset is high.
  assign RegWrite      = regWriteQ & ~Reset;
  assign WriteRegister = writeRegQ;
  assign WriteData     = writeDataQ;

  assign Hazard1 = RegWrite && (ReadRegister1 == writeRegQ) && (writeRegQ != ZERO_REG);
  assign Hazard2 = RegWrite && (ReadRegister2 == writeRegQ) && (writeRegQ != ZERO_REG);

  assign PendingMask = RegWrite ? (REG_COUNT'(1) << writeRegQ) : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  // ---------------- clock / reset ----------------
  logic Clk;
  logic Reset;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- round-robin DUT ----------------
  logic        AValid, AReady, BValid, BReady;
  logic [4:0]  AAddr, BAddr;
  logic [31:0] AData, BData;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic        Hazard1, Hazard2;
  logic [31:0] PendingMask;
  logic        LastGrantB;

  regfile_wb_arbiter #(.PRIORITY_MODE(0), .DROP_ZERO(1)) dutRr (
    .Clk(Clk), .Reset(Reset),
    .AValid(AValid), .AReady(AReady), .AAddr(AAddr), .AData(AData),
    .BValid(BValid), .BReady(BReady), .BAddr(BAddr), .BData(BData),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Hazard1(Hazard1), .Hazard2(Hazard2),
    .PendingMask(PendingMask), .LastGrantB(LastGrantB)
  );

  // ---------------- fixed-priority DUT ----------------
  logic        fAValid, fAReady, fBValid, fBReady;
  logic [4:0]  fAAddr, fBAddr;
  logic [31:0] fAData, fBData;
  logic        fRegWrite;
  logic [4:0]  fWriteRegister;
  logic [31:0] fWriteData;
  logic        fHazard1, fHazard2;
  logic [31:0] fPendingMask;
  logic        fLastGrantB;

  regfile_wb_arbiter #(.PRIORITY_MODE(1), .DROP_ZERO(1)) dutFix (
    .Clk(Clk), .Reset(Reset),
    .AValid(fAValid), .AReady(fAReady), .AAddr(fAAddr), .AData(fAData),
    .BValid(fBValid), .BReady(fBReady), .BAddr(fBAddr), .BData(fBData),
    .RegWrite(fRegWrite), .WriteRegister(fWriteRegister), .WriteData(fWriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Hazard1(fHazard1), .Hazard2(fHazard2),
    .PendingMask(fPendingMask), .LastGrantB(fLastGrantB)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: advance to just after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // ---------------- reference model state ----------------
  // The model tracks which requester the rotation currently favours and the
  // write that should be visible on the port in the following cycle.
  logic [31:0] exp_q[$];
  bit          favourA;
  bit          expWe;
  logic [4:0]  expAddr;
  logic [31:0] expData;
  bit          gA, gB;

  initial begin
    Reset = 1'b1;
    AValid = 1'b0; BValid = 1'b0; AAddr = '0; BAddr = '0; AData = '0; BData = '0;
    fAValid = 1'b0; fBValid = 1'b0; fAAddr = '0; fBAddr = '0; fAData = '0; fBData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;

    // ---- reset with both requesters asserting ----
    AValid = 1'b1; AAddr = 5'd3; AData = 32'h0000_1111;
    BValid = 1'b1; BAddr = 5'd7; BData = 32'h0000_2222;
    fAValid = 1'b1; fAAddr = 5'd3; fAData = 32'h0000_1111;
    fBValid = 1'b1; fBAddr = 5'd7; fBData = 32'h0000_2222;
    ReadRegister1 = 5'd3;
    tick();
    tick();
    chk1 ("rst_aready",    AReady, 1'b0);
    chk1 ("rst_bready",    BReady, 1'b0);
    chk1 ("rst_regwrite",  RegWrite, 1'b0);
    chk32("rst_pmask",     PendingMask, 32'h0);
    chk32("rst_wreg",      32'(WriteRegister), 32'h0);
    chk32("rst_wdata",     WriteData, 32'h0);
    chk1 ("rst_lastb",     LastGrantB, 1'b1);
    chk1 ("rst_haz1",      Hazard1, 1'b0);
    chk1 ("rst_fix_bready", fBReady, 1'b0);

    // ---- contention right after reset ----
    Reset = 1'b0;
    #1;
    chk1("rr_first_aready",  AReady, 1'b1);
    chk1("rr_first_bready",  BReady, 1'b0);
    chk1("fix_first_bready", fBReady, 1'b1);
    chk1("fix_first_aready", fAReady, 1'b0);
    tick();
    AValid = 1'b0; fBValid = 1'b0;
    #1;
    chk1 ("rr_w1_we",     RegWrite, 1'b1);
    chk32("rr_w1_reg",    32'(WriteRegister), 32'd3);
    chk32("rr_w1_data",   WriteData, 32'h0000_1111);
    chk32("rr_w1_pmask",  PendingMask, 32'h0000_0008);
    chk1 ("rr_w1_lastb",  LastGrantB, 1'b0);
    chk1 ("rr_w1_haz1",   Hazard1, 1'b1);
    chk1 ("rr_b_ready",   BReady, 1'b1);
    chk32("fix_w1_reg",   32'(fWriteRegister), 32'd7);
    chk1 ("fix_a_ready",  fAReady, 1'b1);
    chk1 ("fix_w1_lastb", fLastGrantB, 1'b1);
    tick();
    BValid = 1'b0; fAValid = 1'b0;
    #1;
    chk1 ("rr_w2_we",    RegWrite, 1'b1);
    chk32("rr_w2_reg",   32'(WriteRegister), 32'd7);
    chk32("rr_w2_data",  WriteData, 32'h0000_2222);
    chk1 ("rr_w2_lastb", LastGrantB, 1'b1);
    chk1 ("fix_w2_we",   fRegWrite, 1'b1);
    chk32("fix_w2_reg",  32'(fWriteRegister), 32'd3);
    chk32("fix_w2_data", fWriteData, 32'h0000_1111);
    tick();
    #1;
    chk1 ("idle_we",    RegWrite, 1'b0);
    chk32("idle_reg",   32'(WriteRegister), 32'd7);
    chk32("idle_data",  WriteData, 32'h0000_2222);
    chk32("idle_pmask", PendingMask, 32'h0);
    chk1 ("idle_lastb", LastGrantB, 1'b1);
    chk1 ("idle_haz1",  Hazard1, 1'b0);

    // ---- single A write ----
    AValid = 1'b1; AAddr = 5'd5; AData = 32'hDEAD_BEEF;
    #1;
    chk1("single_aready", AReady, 1'b1);
    tick();
    AValid = 1'b0;
    #1;
    chk1 ("single_we",    RegWrite, 1'b1);
    chk32("single_reg",   32'(WriteRegister), 32'd5);
    chk32("single_data",  WriteData, 32'hDEAD_BEEF);
    chk32("single_pmask", PendingMask, 32'h0000_0020);
    tick();
    #1;
    chk1("single_done_we", RegWrite, 1'b0);

    // ---- write to register 0 is consumed but dropped ----
    BValid = 1'b1; BAddr = 5'd0; BData = 32'hFFFF_FFFF; ReadRegister1 = 5'd0;
    #1;
    chk1("zero_bready", BReady, 1'b1);
    chk1("zero_aready", AReady, 1'b0);
    tick();
    BValid = 1'b0;
    #1;
    chk1 ("zero_we",    RegWrite, 1'b0);
    chk1 ("zero_haz1",  Hazard1, 1'b0);
    chk32("zero_pmask", PendingMask, 32'h0);
    chk32("zero_reg",   32'(WriteRegister), 32'd0);
    chk32("zero_data",  WriteData, 32'hFFFF_FFFF);
    chk1 ("zero_lastb", LastGrantB, 1'b1);

    // ---- hazard flags ----
    AValid = 1'b1; AAddr = 5'd9; AData = 32'h0000_0099;
    ReadRegister1 = 5'd9; ReadRegister2 = 5'd4;
    tick();
    AValid = 1'b0;
    #1;
    chk1 ("haz_h1",    Hazard1, 1'b1);
    chk1 ("haz_h2",    Hazard2, 1'b0);
    chk32("haz_pmask", PendingMask, 32'h0000_0200);
    tick();

    // ---- reset pulsed while the write is on the port ----
    AValid = 1'b1; AAddr = 5'd9; AData = 32'h0000_1234;
    #1;
    chk1("rmid_aready", AReady, 1'b1);
    tick();
    AValid = 1'b0;
    #1;
    chk1("rmid_pre_we", RegWrite, 1'b1);
    Reset = 1'b1;
    #1;
    chk1 ("rmid_we_during", RegWrite, 1'b0);
    chk1 ("rmid_h1_during", Hazard1, 1'b0);
    chk32("rmid_pm_during", PendingMask, 32'h0);
    tick();
    Reset = 1'b0;
    #1;
    chk1 ("rmid_we_after",  RegWrite, 1'b0);
    chk32("rmid_reg_after", 32'(WriteRegister), 32'd0);
    chk1 ("rmid_lastb",     LastGrantB, 1'b1);

    // ---- randomized traffic against the reference model (round-robin) ----
    // Reset state: A favoured first, port idle, address/data zero.
    favourA = 1'b1;
    expWe   = 1'b0;
    expAddr = '0;
    expData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!AValid && $urandom_range(0, 2) != 0) begin
        AValid = 1'b1; AAddr = 5'($urandom_range(0, 31)); AData = $urandom;
      end
      if (!BValid && $urandom_range(0, 2) != 0) begin
        BValid = 1'b1; BAddr = 5'($urandom_range(0, 31)); BData = $urandom;
      end
      ReadRegister1 = ($urandom_range(0, 1) == 1) ? expAddr : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 1) == 1) ? expAddr : 5'($urandom_range(0, 31));
      #1;
      // write port shows whatever was granted in the previous cycle
      chk1 ("rnd_we",    RegWrite, expWe);
      chk32("rnd_reg",   32'(WriteRegister), 32'(expAddr));
      chk32("rnd_data",  WriteData, expData);
      chk32("rnd_pmask", PendingMask, expWe ? (32'h1 << expAddr) : 32'h0);
      chk1 ("rnd_h1",    Hazard1, expWe && (ReadRegister1 == expAddr) && (expAddr != 0));
      chk1 ("rnd_h2",    Hazard2, expWe && (ReadRegister2 == expAddr) && (expAddr != 0));
      // who should win this cycle
      gA = AValid && (!BValid || favourA);
      gB = BValid && !gA;
      chk1("rnd_aready", AReady, gA);
      chk1("rnd_bready", BReady, gB);
      if (gA) begin
        expWe = (AAddr != 0); expAddr = AAddr; expData = AData; favourA = 1'b0;
        if (AAddr != 0) exp_q.push_back(AData);
      end else if (gB) begin
        expWe = (BAddr != 0); expAddr = BAddr; expData = BData; favourA = 1'b1;
        if (BAddr != 0) exp_q.push_back(BData);
      end else begin
        expWe = 1'b0;
      end
      tick();
      if (gA) AValid = 1'b0;
      if (gB) BValid = 1'b0;
      // every enabled write must carry the oldest outstanding granted data
      if (RegWrite) begin
        if (exp_q.size() == 0) begin
          chk1("rnd_unexpected_write", RegWrite, 1'b0);
        end else begin
          chk32("rnd_stream", WriteData, exp_q.pop_front());
        end
      end
    end
    chk32("rnd_q_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
